mvb_gather: RTL and testbench



---
 rtl/mvb_gather.sv | 108 ++++++++++
 tb/tb_mvb_gather.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mvb_gather.sv
// Purpose: widening MVB gatherer. It packs the valid RX items in order and emits dense TX words.
// Latency: an accepted item becomes visible on TX one cycle after its acceptance edge.
// Backpressure: rx_dst_rdy is high while count <= OUTPUTS, and it is driven from registers only.
module mvb_gather #(
    parameter int INPUTS     = 2,
    parameter int OUTPUTS    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [INPUTS*DATA_WIDTH-1:0]  rx_data,
    input  logic [INPUTS-1:0]             rx_vld,
    input  logic                          rx_src_rdy,
    output logic                          rx_dst_rdy,
    output logic [OUTPUTS*DATA_WIDTH-1:0] tx_data,
    output logic [OUTPUTS-1:0]            tx_vld,
    output logic                          tx_src_rdy,
    input  logic                          tx_dst_rdy
);

    localparam int CAP = OUTPUTS + INPUTS;
    localparam int CW  = $clog2(CAP + 1);
    localparam int IW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [DATA_WIDTH-1:0] slot_q [CAP];
    logic [DATA_WIDTH-1:0] slot_d [CAP];
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [IW-1:0]         idle_q;
    logic [IW-1:0]         idle_d;
    logic                  flush;
    logic                  rx_fire;
    logic                  tx_fire;
    int                    pop;
    int                    wr;

    // Accept a new word only while one full TX word is the worst case that is already buffered.
    assign rx_dst_rdy = (count_q <= CW'(OUTPUTS));
    assign flush      = (TIMEOUT != 0) && (idle_q == IW'(TIMEOUT));
    assign tx_src_rdy = (count_q >= CW'(OUTPUTS)) || (flush && (count_q != '0));
    assign rx_fire    = rx_src_rdy && rx_dst_rdy;
    assign tx_fire    = tx_src_rdy && tx_dst_rdy;

    // Present the oldest OUTPUTS slots, with a contiguous valid prefix taken from the occupancy.
    always_comb begin
        tx_data = '0;
        tx_vld  = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            tx_data[i*DATA_WIDTH +: DATA_WIDTH] = slot_q[i];
            tx_vld[i] = (CW'(i) < count_q);
        end
    end

    // Next buffer state. A TX pop first shifts the buffer down, then the valid RX items are appended in index order.
    always_comb begin
        pop = 0;
        if (tx_fire) begin
            pop = (int'(count_q) < OUTPUTS) ? int'(count_q) : OUTPUTS;
        end
        for (int j = 0; j < CAP; j++) begin
            slot_d[j] = slot_q[j];
            for (int k = 0; k < CAP; k++) begin
                if (k == j + pop) begin
                    slot_d[j] = slot_q[k];
                end
            end
        end
        wr = int'(count_q) - pop;
        if (rx_fire) begin
            for (int i = 0; i < INPUTS; i++) begin
                if (rx_vld[i]) begin
                    for (int j = 0; j < CAP; j++) begin
                        if (j == wr) begin
                            slot_d[j] = rx_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    wr = wr + 1;
                end
            end
        end
        count_d = CW'(wr);
        idle_d  = idle_q;
        if (rx_fire || (count_q == '0) || (count_d == '0)) begin
            idle_d = '0;
        end else if (idle_q != IW'(TIMEOUT)) begin
            idle_d = idle_q + IW'(1);
        end
    end

    // Buffer, occupancy and idle counter registers. Reset discards all buffered items immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            idle_q  <= '0;
            for (int j = 0; j < CAP; j++) begin
                slot_q[j] <= '0;
            end
        end else begin
            count_q <= count_d;
            idle_q  <= idle_d;
            for (int j = 0; j < CAP; j++) begin
                slot_q[j] <= slot_d[j];
            end
        end
    end

endmodule

// File: tb/tb_mvb_gather.sv
// Purpose: directed self-checking bench for mvb_gather, built with INPUTS=2, OUTPUTS=4 and DATA_WIDTH=16.
// Latency: inputs are driven and outputs are sampled 1 ns after each rising edge.
// Backpressure: the sink-ready input is driven directly, and a second instance checks the behaviour with TIMEOUT=0.
module tb_mvb_gather;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rx_data;
    logic [1:0]  rx_vld;
    logic        rx_src_rdy;
    logic        rx_dst_rdy;
    logic [63:0] tx_data;
    logic [3:0]  tx_vld;
    logic        tx_src_rdy;
    logic        tx_dst_rdy;

    logic [31:0] z_rx_data;
    logic [1:0]  z_rx_vld;
    logic        z_rx_src_rdy;
    logic        z_rx_dst_rdy;
    logic [63:0] z_tx_data;
    logic [3:0]  z_tx_vld;
    logic        z_tx_src_rdy;
    logic        z_tx_dst_rdy;

    int checks = 0;
    int errors = 0;

    // Toggle the clock to give a 10 ns period.
    always #5 clk = ~clk;

    mvb_gather #(.INPUTS(2), .OUTPUTS(4), .DATA_WIDTH(16), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(rst_n),
        .rx_data(rx_data), .rx_vld(rx_vld), .rx_src_rdy(rx_src_rdy), .rx_dst_rdy(rx_dst_rdy),
        .tx_data(tx_data), .tx_vld(tx_vld), .tx_src_rdy(tx_src_rdy), .tx_dst_rdy(tx_dst_rdy)
    );

    mvb_gather #(.INPUTS(2), .OUTPUTS(4), .DATA_WIDTH(16), .TIMEOUT(0)) dut_z (
        .clk(clk), .reset_n(rst_n),
        .rx_data(z_rx_data), .rx_vld(z_rx_vld), .rx_src_rdy(z_rx_src_rdy), .rx_dst_rdy(z_rx_dst_rdy),
        .tx_data(z_tx_data), .tx_vld(z_tx_vld), .tx_src_rdy(z_tx_src_rdy), .tx_dst_rdy(z_tx_dst_rdy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] vld, input logic [15:0] d1, input logic [15:0] d0);
        rx_src_rdy = 1'b1;
        rx_vld     = vld;
        rx_data    = {d1, d0};
    endtask

    task automatic idle_rx();
        rx_src_rdy = 1'b0;
        rx_vld     = 2'b00;
        rx_data    = '0;
    endtask

    // Wait a bounded number of cycles for a TX word. An expired bound counts as a failed comparison.
    task automatic wait_tx(input string tag);
        int n;
        n = 0;
        while (!tx_src_rdy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, tx_src_rdy}, 64'd1);
    endtask

    initial begin
        logic seen;
        rst_n        = 1'b0;
        tx_dst_rdy   = 1'b1;
        z_tx_dst_rdy = 1'b1;
        z_rx_src_rdy = 1'b0;
        z_rx_vld     = 2'b00;
        z_rx_data    = '0;
        idle_rx();
        #1;
        chk("rst_rx_dst_rdy", {63'd0, rx_dst_rdy}, 64'd1);
        chk("rst_tx_src_rdy", {63'd0, tx_src_rdy}, 64'd0);
        chk("rst_tx_vld", {60'd0, tx_vld}, 64'd0);
        chk("rst_tx_data", tx_data, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Two all-valid words fill exactly one TX word.
        drive(2'b11, 16'h00B0, 16'h00A0);
        tick();
        chk("basic_half_no_tx", {63'd0, tx_src_rdy}, 64'd0);
        drive(2'b11, 16'h00D0, 16'h00C0);
        tick();
        idle_rx();
        chk("basic_tx_rdy", {63'd0, tx_src_rdy}, 64'd1);
        chk("basic_tx_vld", {60'd0, tx_vld}, 64'hF);
        chk("basic_tx_data", tx_data, 64'h00D0_00C0_00B0_00A0);
        tick();
        chk("basic_count_after", {61'd0, dut.count_q}, 64'd0);

        // Sparse words are compacted in order.
        drive(2'b10, 16'h00E0, 16'hDEAD);
        tick();
        drive(2'b01, 16'hBEEF, 16'h00F0);
        tick();
        drive(2'b01, 16'hBEEF, 16'h0010);
        tick();
        chk("sparse_count3", {61'd0, dut.count_q}, 64'd3);
        chk("sparse_no_tx", {63'd0, tx_src_rdy}, 64'd0);
        drive(2'b11, 16'h0030, 16'h0020);
        tick();
        idle_rx();
        chk("sparse_tx_data", tx_data, 64'h0020_0010_00F0_00E0);
        chk("sparse_tx_vld", {60'd0, tx_vld}, 64'hF);
        chk("sparse_rx_stall", {63'd0, rx_dst_rdy}, 64'd0);
        tick();
        chk("sparse_left_count", {61'd0, dut.count_q}, 64'd1);
        chk("sparse_left_vld", {60'd0, tx_vld}, 64'h1);
        chk("sparse_left_data", {48'd0, tx_data[15:0]}, 64'h0030);
        wait_tx("sparse_flush_rdy");
        chk("sparse_flush_vld", {60'd0, tx_vld}, 64'h1);
        tick();
        chk("sparse_flush_empty", {61'd0, dut.count_q}, 64'd0);

        // Under backpressure the buffer fills to six items, and RX then stalls.
        tx_dst_rdy = 1'b0;
        drive(2'b11, 16'h0002, 16'h0001);
        tick();
        drive(2'b11, 16'h0004, 16'h0003);
        tick();
        chk("bp_rdy_at4", {63'd0, rx_dst_rdy}, 64'd1);
        drive(2'b11, 16'h0006, 16'h0005);
        tick();
        chk("bp_rx_stall", {63'd0, rx_dst_rdy}, 64'd0);
        drive(2'b11, 16'h0008, 16'h0007);
        tick();
        tick();
        chk("bp_count6", {61'd0, dut.count_q}, 64'd6);
        chk("bp_hold_data", tx_data, 64'h0004_0003_0002_0001);
        idle_rx();
        tx_dst_rdy = 1'b1;
        tick();
        chk("bp_count2", {61'd0, dut.count_q}, 64'd2);
        chk("bp_rest_data", {32'd0, tx_data[31:0]}, 64'h0006_0005);
        wait_tx("bp_flush_rdy");
        chk("bp_flush_vld", {60'd0, tx_vld}, 64'h3);
        chk("bp_flush_data", {32'd0, tx_data[31:0]}, 64'h0006_0005);
        tick();
        chk("bp_empty", {61'd0, dut.count_q}, 64'd0);

        // The exact timeout: TX is low through idle cycle 15 and high at 16.
        drive(2'b11, 16'h00B1, 16'h00A1);
        tick();
        idle_rx();
        for (int k = 0; k < 15; k++) begin
            tick();
        end
        chk("to_not_early", {63'd0, tx_src_rdy}, 64'd0);
        tick();
        chk("to_rdy", {63'd0, tx_src_rdy}, 64'd1);
        chk("to_vld", {60'd0, tx_vld}, 64'h3);
        chk("to_data", {32'd0, tx_data[31:0]}, 64'h00B1_00A1);
        tick();
        chk("to_count0", {61'd0, dut.count_q}, 64'd0);
        chk("to_idle0", {59'd0, dut.idle_q}, 64'd0);

        // A pop and an append happen in the same cycle.
        drive(2'b11, 16'h0B02, 16'h0A02);
        tick();
        drive(2'b11, 16'h0D02, 16'h0C02);
        tick();
        drive(2'b11, 16'h0F02, 16'h0E02);
        tick();
        chk("sim_count2", {61'd0, dut.count_q}, 64'd2);
        chk("sim_data", {32'd0, tx_data[31:0]}, 64'h0F02_0E02);
        chk("sim_vld", {60'd0, tx_vld}, 64'h3);
        drive(2'b01, 16'h0000, 16'h0102);
        tick();
        idle_rx();
        chk("sim_count3", {61'd0, dut.count_q}, 64'd3);

        // An asynchronous reset in mid-cycle discards all buffered items.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", {61'd0, dut.count_q}, 64'd0);
        chk("mid_rst_vld", {60'd0, tx_vld}, 64'h0);
        chk("mid_rst_data", tx_data, 64'd0);
        chk("mid_rst_rx_rdy", {63'd0, rx_dst_rdy}, 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        drive(2'b11, 16'h0222, 16'h0111);
        tick();
        drive(2'b11, 16'h0444, 16'h0333);
        tick();
        idle_rx();
        chk("post_rst_vld", {60'd0, tx_vld}, 64'hF);
        chk("post_rst_data", tx_data, 64'h0444_0333_0222_0111);
        tick();

        // With TIMEOUT=0 a partial word is never flushed.
        z_rx_src_rdy = 1'b1;
        z_rx_vld     = 2'b11;
        z_rx_data    = {16'h00B9, 16'h00A9};
        tick();
        z_rx_src_rdy = 1'b0;
        z_rx_vld     = 2'b00;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (z_tx_src_rdy) seen = 1'b1;
        end
        chk("to0_never_tx", {63'd0, seen}, 64'd0);
        chk("to0_count2", {61'd0, dut_z.count_q}, 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
